// File: rtl/t05_least_pair_scan.sv
// Streams every entry of a value memory and keeps the two smallest nonzero values with their indices.
// Optional macro T05_LEAST_PAIR_SAT_SUM_EN makes the pair sum saturate on carry-out and raise ovf.
module t05_least_pair_scan #(
  parameter  int VAL_W    = 64,
  parameter  int NUM_LEAF = 256,
  parameter  int NUM_NODE = 128,
  localparam int TOTAL    = NUM_LEAF + NUM_NODE,
  localparam int IDX_W    = $clog2(TOTAL)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             abort,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_idx,
  input  logic [VAL_W-1:0] rd_val,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] least1_idx,
  output logic [IDX_W-1:0] least2_idx,
  output logic             least1_leaf,
  output logic             least2_leaf,
  output logic [1:0]       found,
  output logic [VAL_W-1:0] sum,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);
  localparam logic [IDX_W-1:0] LEAF_LIM = IDX_W'(NUM_LEAF);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]   cmp_idx_q;
  logic               cmp_vld_q;
  logic               launch, finish;

  logic [VAL_W-1:0]   best1_val_q, best1_val_d, best2_val_q, best2_val_d;
  logic [IDX_W-1:0]   best1_idx_q, best1_idx_d, best2_idx_q, best2_idx_d;
  logic [1:0]         cnt_q, cnt_d;

  logic [IDX_W-1:0]   l1_idx_q, l2_idx_q;
  logic               l1_leaf_q, l2_leaf_q;
  logic [1:0]         found_q;
  logic [VAL_W-1:0]   sum_q, sum_d;
  logic               ovf_q, ovf_d;

  always_comb begin
    state_d  = state_q;
    rd_idx_d = rd_idx_q;
    launch   = 1'b0;
    finish   = 1'b0;
    case (state_q)
      IDLE: begin
        rd_idx_d = '0;
        if (start && !abort) begin
          state_d = SCAN;
          launch  = 1'b1;
        end
      end
      SCAN: begin
        if (abort) begin
          state_d  = IDLE;
          rd_idx_d = '0;
        end else if (rd_idx_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          rd_idx_d = rd_idx_q + 1'b1;
        end
      end
      DRAIN: begin
        rd_idx_d = '0;
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          finish  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strict less-than keeps the earlier (lower) index on equal values.
  always_comb begin
    best1_val_d = best1_val_q;
    best1_idx_d = best1_idx_q;
    best2_val_d = best2_val_q;
    best2_idx_d = best2_idx_q;
    cnt_d       = cnt_q;
    if (launch) begin
      best1_val_d = '1;
      best1_idx_d = '0;
      best2_val_d = '1;
      best2_idx_d = '0;
      cnt_d       = 2'd0;
    end else if (cmp_vld_q && (rd_val != '0)) begin
      cnt_d = (cnt_q == 2'd2) ? 2'd2 : cnt_q + 2'd1;
      if (rd_val < best1_val_q) begin
        best2_val_d = best1_val_q;
        best2_idx_d = best1_idx_q;
        best1_val_d = rd_val;
        best1_idx_d = cmp_idx_q;
      end else if (rd_val < best2_val_q) begin
        best2_val_d = rd_val;
        best2_idx_d = cmp_idx_q;
      end
    end
  end

`ifdef T05_LEAST_PAIR_SAT_SUM_EN
  logic [VAL_W:0] sum_full;
  assign sum_full = {1'b0, best1_val_d} + {1'b0, best2_val_d};
  always_comb begin
    sum_d = '0;
    ovf_d = 1'b0;
    if (cnt_d == 2'd2) begin
      sum_d = sum_full[VAL_W] ? {VAL_W{1'b1}} : sum_full[VAL_W-1:0];
      ovf_d = sum_full[VAL_W];
    end
  end
`else
  always_comb begin
    sum_d = '0;
    ovf_d = 1'b0;
    if (cnt_d == 2'd2) sum_d = best1_val_d + best2_val_d;
  end
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      rd_idx_q    <= '0;
      cmp_idx_q   <= '0;
      cmp_vld_q   <= 1'b0;
      best1_val_q <= '1;
      best1_idx_q <= '0;
      best2_val_q <= '1;
      best2_idx_q <= '0;
      cnt_q       <= 2'd0;
      l1_idx_q    <= '0;
      l2_idx_q    <= '0;
      l1_leaf_q   <= 1'b0;
      l2_leaf_q   <= 1'b0;
      found_q     <= 2'd0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_idx_q    <= rd_idx_d;
      cmp_idx_q   <= rd_idx_q;
      cmp_vld_q   <= (state_q == SCAN) && !abort;
      best1_val_q <= best1_val_d;
      best1_idx_q <= best1_idx_d;
      best2_val_q <= best2_val_d;
      best2_idx_q <= best2_idx_d;
      cnt_q       <= cnt_d;
      // Results are captured from the next-state bests so the final drained value is included.
      if (finish) begin
        found_q   <= cnt_d;
        l1_idx_q  <= (cnt_d != 2'd0) ? best1_idx_d : '0;
        l1_leaf_q <= (cnt_d != 2'd0) && (best1_idx_d < LEAF_LIM);
        l2_idx_q  <= (cnt_d == 2'd2) ? best2_idx_d : '0;
        l2_leaf_q <= (cnt_d == 2'd2) && (best2_idx_d < LEAF_LIM);
        sum_q     <= sum_d;
        ovf_q     <= ovf_d;
      end
    end
  end

  assign rd_en       = (state_q == SCAN);
  assign rd_idx      = rd_idx_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign least1_idx  = l1_idx_q;
  assign least2_idx  = l2_idx_q;
  assign least1_leaf = l1_leaf_q;
  assign least2_leaf = l2_leaf_q;
  assign found       = found_q;
  assign sum         = sum_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_t05_least_pair_scan.sv
// Directed bench: default-size scanner plus a small 8-bit instance for the sum overflow case.
module tb_t05_least_pair_scan;
  localparam int TOTAL = 384;

`ifdef T05_LEAST_PAIR_SAT_SUM_EN
  localparam logic [63:0] BIG_SUM = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic        BIG_OVF = 1'b1;
  localparam logic [7:0]  S_SUM   = 8'd255;
  localparam logic        S_OVF   = 1'b1;
`else
  localparam logic [63:0] BIG_SUM = 64'h4000_0000_0000_0000;
  localparam logic        BIG_OVF = 1'b0;
  localparam logic [7:0]  S_SUM   = 8'd44;
  localparam logic        S_OVF   = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst, start, abort;
  logic        rd_en, busy, done, l1_leaf, l2_leaf, ovf;
  logic [8:0]  rd_idx, l1_idx, l2_idx;
  logic [63:0] rd_val, sum;
  logic [1:0]  found;

  logic        s_start, s_abort;
  logic        s_rd_en, s_busy, s_done, s_l1_leaf, s_l2_leaf, s_ovf;
  logic [2:0]  s_rd_idx, s_l1_idx, s_l2_idx;
  logic [7:0]  s_rd_val, s_sum;
  logic [1:0]  s_found;

  logic [63:0] mem [TOTAL];
  logic [7:0]  s_mem [6];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int start_cyc;
  int lat;
  bit got;

  t05_least_pair_scan dut (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_val(rd_val),
    .busy(busy), .done(done),
    .least1_idx(l1_idx), .least2_idx(l2_idx),
    .least1_leaf(l1_leaf), .least2_leaf(l2_leaf),
    .found(found), .sum(sum), .ovf(ovf)
  );

  t05_least_pair_scan #(.VAL_W(8), .NUM_LEAF(4), .NUM_NODE(2)) sdut (
    .clk(clk), .nrst(nrst), .start(s_start), .abort(s_abort),
    .rd_en(s_rd_en), .rd_idx(s_rd_idx), .rd_val(s_rd_val),
    .busy(s_busy), .done(s_done),
    .least1_idx(s_l1_idx), .least2_idx(s_l2_idx),
    .least1_leaf(s_l1_leaf), .least2_leaf(s_l2_leaf),
    .found(s_found), .sum(s_sum), .ovf(s_ovf)
  );

  // Value memories answer one cycle after the read strobe; idle cycles return a small nonzero decoy.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rd_val   <= rd_en ? mem[rd_idx] : 64'd1;
    s_rd_val <= s_rd_en ? s_mem[s_rd_idx] : 8'd1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mem();
    for (int i = 0; i < TOTAL; i++) mem[i] = 64'd0;
  endtask

  task automatic start_scan();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit g, output int l);
    g = 1'b0;
    l = 0;
    for (int i = 0; i < 600; i++) begin
      if (done) begin
        g = 1'b1;
        l = cyc - start_cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic chk_result(input string tag, input logic [8:0] i1, input logic [8:0] i2,
                            input logic lf1, input logic lf2, input logic [1:0] f,
                            input logic [63:0] s, input logic o);
    $display("txn %s: l1=%0d l2=%0d found=%0d sum=%0h ovf=%0b", tag, l1_idx, l2_idx, found, sum, ovf);
    chk({tag, "_done"}, got, 1'b1);
    chk({tag, "_lat"}, lat, TOTAL + 2);
    chk({tag, "_l1"}, l1_idx, i1);
    chk({tag, "_l2"}, l2_idx, i2);
    chk({tag, "_leaf1"}, l1_leaf, lf1);
    chk({tag, "_leaf2"}, l2_leaf, lf2);
    chk({tag, "_found"}, found, f);
    chk({tag, "_sum"}, sum, s);
    chk({tag, "_ovf"}, ovf, o);
  endtask

  task automatic chk_reset(input string tag);
    $display("txn %s: reset state check", tag);
    chk({tag, "_rd_en"}, rd_en, 1'b0);
    chk({tag, "_rd_idx"}, rd_idx, 9'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_l1"}, l1_idx, 9'd0);
    chk({tag, "_l2"}, l2_idx, 9'd0);
    chk({tag, "_leaf1"}, l1_leaf, 1'b0);
    chk({tag, "_found"}, found, 2'd0);
    chk({tag, "_sum"}, sum, 64'd0);
    chk({tag, "_ovf"}, ovf, 1'b0);
  endtask

  initial begin
    bit saw_done;
    nrst = 1'b0; start = 1'b0; abort = 1'b0;
    s_start = 1'b0; s_abort = 1'b0;
    clr_mem();
    for (int i = 0; i < 6; i++) s_mem[i] = 8'd0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    nrst = 1'b1;

    // Two leaves and one node; smallest is leaf 66
    mem[65] = 64'd5; mem[66] = 64'd3; mem[256] = 64'd9;
    start_scan();
    chk("scan_busy", busy, 1'b1);
    chk("scan_rd_en", rd_en, 1'b1);
    wait_done(got, lat);
    chk_result("basic", 9'd66, 9'd65, 1'b1, 1'b1, 2'd2, 64'd8, 1'b0);
    @(negedge clk);
    chk("basic_done_pulse", done, 1'b0);
    chk("basic_idle", busy, 1'b0);
    chk("basic_hold", l1_idx, 9'd66);

    // Equal values: lower indices win
    clr_mem();
    mem[10] = 64'd4; mem[20] = 64'd4; mem[300] = 64'd4;
    start_scan();
    repeat (100) @(negedge clk);
    chk("tie_midscan_hold_l1", l1_idx, 9'd66);
    chk("tie_midscan_hold_sum", sum, 64'd8);
    wait_done(got, lat);
    chk_result("tie", 9'd10, 9'd20, 1'b1, 1'b1, 2'd2, 64'd8, 1'b0);

    // Only the root node is populated
    clr_mem();
    mem[257] = 64'd100;
    start_scan();
    wait_done(got, lat);
    chk_result("root", 9'd257, 9'd0, 1'b0, 1'b0, 2'd1, 64'd0, 1'b0);

    // Sum carry-out at full width
    clr_mem();
    mem[0] = 64'hC000_0000_0000_0000; mem[1] = 64'h8000_0000_0000_0000;
    start_scan();
    wait_done(got, lat);
    chk_result("bigsum", 9'd1, 9'd0, 1'b1, 1'b1, 2'd2, BIG_SUM, BIG_OVF);

    // 8-bit instance: 200 + 100
    s_mem[0] = 8'd200; s_mem[1] = 8'd100;
    @(negedge clk);
    s_start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    s_start = 1'b0;
    got = 1'b0; lat = 0;
    for (int i = 0; i < 50; i++) begin
      if (s_done) begin
        got = 1'b1;
        lat = cyc - start_cyc;
        break;
      end
      @(negedge clk);
    end
    $display("txn small: l1=%0d l2=%0d sum=%0d ovf=%0b", s_l1_idx, s_l2_idx, s_sum, s_ovf);
    chk("small_done", got, 1'b1);
    chk("small_lat", lat, 8);
    chk("small_l1", s_l1_idx, 3'd1);
    chk("small_l2", s_l2_idx, 3'd0);
    chk("small_sum", s_sum, S_SUM);
    chk("small_ovf", s_ovf, S_OVF);

    // Abort mid-scan, with an ignored start pulse before it
    clr_mem();
    mem[5] = 64'd7; mem[6] = 64'd2;
    start_scan();
    repeat (29) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_start_ignored", rd_idx, 9'd50);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    $display("txn abort: busy=%0b rd_en=%0b", busy, rd_en);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rd_en", rd_en, 1'b0);
    saw_done = 1'b0;
    repeat (400) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 1'b0);
    chk("abort_keep_l1", l1_idx, 9'd1);
    chk("abort_keep_sum", sum, BIG_SUM);

    // start and abort together in IDLE
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", busy, 1'b0);

    start_scan();
    wait_done(got, lat);
    chk_result("post_abort", 9'd6, 9'd5, 1'b1, 1'b1, 2'd2, 64'd9, 1'b0);

    // Asynchronous reset in the middle of a scan
    start_scan();
    repeat (99) @(negedge clk);
    chk("pre_reset_busy", busy, 1'b1);
    nrst = 1'b0;
    #1;
    chk_reset("midreset");
    @(negedge clk);
    nrst = 1'b1;
    start_scan();
    wait_done(got, lat);
    chk_result("post_reset", 9'd6, 9'd5, 1'b1, 1'b1, 2'd2, 64'd9, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/t05_least_pair_scan.md
T05_LEAST_PAIR_SCAN -- requirements
Module: t05_least_pair_scan

Interface
REQ-001 Parameter VAL_W, default 64: width of each frequency/weight value.
REQ-002 Parameter NUM_LEAF, default 256: leaf entries, indices 0..NUM_LEAF-1.
REQ-003 Parameter NUM_NODE, default 128: node entries, indices NUM_LEAF..NUM_LEAF+NUM_NODE-1; TOTAL = NUM_LEAF+NUM_NODE; IDX_W = clog2(TOTAL).
REQ-004 Ports are as follows; reset is asynchronous, active-low (nrst); single clock clk.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 nrst  in  1  asynchronous active-low reset.
REQ-007 start  in  1  one-cycle scan request, honoured only in IDLE.
REQ-008 abort  in  1  cancels a scan in progress, no done pulse.
REQ-009 rd_en  out  1  read strobe to value memory.
REQ-010 rd_idx  out  IDX_W  entry index being read.
REQ-011 rd_val  in  VAL_W  value of entry rd_idx, valid exactly one cycle after rd_en.
REQ-012 busy  out  1  high in SCAN, DRAIN, DONE.
REQ-013 done  out  1  one-cycle pulse, results final.
REQ-014 least1_idx / least2_idx  out  IDX_W  indices of smallest / second-smallest nonzero value.
REQ-015 least1_leaf / least2_leaf  out  1  index is below NUM_LEAF.
REQ-016 found  out  2  nonzero entries seen, saturating at 2.
REQ-017 sum  out  VAL_W  value(least1)+value(least2); ovf  out  1  sum overflow flag.

Function
REQ-018 FSM states IDLE, SCAN, DRAIN, DONE; IDLE->SCAN on start, SCAN->DRAIN after issuing index TOTAL-1, DRAIN->DONE, DONE->IDLE unconditionally.
REQ-019 On entering SCAN, best values clear to all-ones, found clears to 0, rd_idx starts at 0.
REQ-020 SCAN: rd_en=1, rd_idx increments by 1 per cycle from 0 to TOTAL-1, no wrap.
REQ-021 Each cycle after an issued read (SCAN cycles 2..TOTAL and DRAIN), rd_val is compared for index rd_idx-1.
REQ-022 Zero values ignored (unused symbol/node); found unchanged.
REQ-023 v < best1: best2 <= best1 (value, index), best1 <= v; else v < best2: best2 <= v; strict compare, so on ties lower index wins.
REQ-024 found increments per nonzero value, saturating at 2.
REQ-025 DONE: done=1 one cycle; outputs registered from best1/best2; sum computed only when found==2, else sum=0, ovf=0.
REQ-026 found==1: least2_idx=0, least2_leaf=0, least1 valid (tree root reached).
REQ-027 Outputs hold from DONE until next start; unchanged during next SCAN until its DONE.
REQ-028 start while busy ignored; start and abort in same IDLE cycle: abort wins, stays IDLE.
REQ-029 abort in SCAN/DRAIN: next state IDLE, rd_en=0, outputs keep previous results, no done; abort in DONE ignored.
REQ-030 Latency: start at edge k -> done high during cycle k+TOTAL+2.

Reset
REQ-031 nrst low: FSM IDLE, rd_en=0, rd_idx=0, busy=0, done=0, least*_idx=0, least*_leaf=0, found=0, sum=0, ovf=0, best values all-ones, asynchronously and mid-scan alike.
REQ-032 First start after reset release behaves as a fresh scan.

Configuration
REQ-033 Macro T05_LEAST_PAIR_SAT_SUM_EN defined: sum saturates to all-ones on carry-out, ovf=1 in that case.
REQ-034 Macro absent: sum wraps modulo 2^VAL_W, ovf tied 0; all other behaviour identical.

Verification
REQ-035 Leaf 65=5, leaf 66=3, node 256=9, rest 0; start -> done at cycle start+386, least1_idx=66, least2_idx=65, both leaf=1, found=2, sum=8.
REQ-036 Leaf 10=4, leaf 20=4, node 300=4 -> least1_idx=10, least2_idx=20 (tie rule), sum=8.
REQ-037 Only node 257=100 nonzero -> found=1, least1_idx=257, least1_leaf=0, least2_idx=0, sum=0.
REQ-038 VAL_W=8, leaves 0=200, 1=100: with SAT_SUM_EN sum=255, ovf=1; without sum=44, ovf=0.
REQ-039 abort at scan cycle 50 -> IDLE next cycle, no done, prior results unchanged; start mid-scan has no effect.
REQ-040 nrst asserted at scan cycle 100 -> all outputs at reset values immediately; new start yields correct result.
